// File: rtl/wash_cycle_sequencer.sv
// Laundry wash-cycle sequencer: runs fill / wash / drain / rinse / spin
// phases for the program sold by the credit FSM and drives the valves,
// drum motor and door lock. Phase timing comes from a shared prescaler.
module wash_cycle_sequencer #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned WASH_BB  = 6,
  parameter int unsigned WASH_CB  = 8,
  parameter int unsigned WASH_SB  = 12,
  parameter int unsigned RINSE_T  = 4,
  parameter int unsigned SPIN_T   = 5,
  parameter int unsigned SPIN_SB  = 8,
  parameter int unsigned FILL_MAX = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       prog_bb,
  input  logic       prog_cb,
  input  logic       prog_sb,
  input  logic       door_closed,
  input  logic       level_full,
  input  logic       level_empty,
  input  logic       pause,
  output logic       start_ack,
  output logic       busy,
  output logic       door_lock,
  output logic       fill_valve,
  output logic       drain_valve,
  output logic       motor_wash,
  output logic       motor_spin,
  output logic       done,
  output logic       fault,
  output logic [3:0] phase,
  output logic [7:0] remaining
);

  localparam int unsigned PW = $clog2(TICK_DIV);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FILL   = 4'd1,
    S_WASH   = 4'd2,
    S_DRAIN  = 4'd3,
    S_RFILL  = 4'd4,
    S_RINSE  = 4'd5,
    S_RDRAIN = 4'd6,
    S_SPIN   = 4'd7,
    S_DONE   = 4'd8,
    S_FAULT  = 4'd9
  } state_t;

  typedef enum logic [1:0] {
    P_BB = 2'd0,
    P_CB = 2'd1,
    P_SB = 2'd2
  } prog_t;

  state_t        state_q, state_d;
  prog_t         prog_q, prog_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    timer_q, timer_d;
  logic [7:0]    tcnt_q, tcnt_d;
  logic [1:0]    rinse_q, rinse_d;
  logic          ack_q, ack_d;

  logic active, timed, frozen, tick, timeout, phase_end, accept;

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      prog_q  <= P_BB;
      presc_q <= '0;
      timer_q <= '0;
      tcnt_q  <= '0;
      rinse_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prog_q  <= prog_d;
      presc_q <= presc_d;
      timer_q <= timer_d;
      tcnt_q  <= tcnt_d;
      rinse_q <= rinse_d;
      ack_q   <= ack_d;
    end
  end

  // Status decode shared by next-state and datapath logic
  always_comb begin
    active    = state_q inside {S_FILL, S_WASH, S_DRAIN, S_RFILL, S_RINSE, S_RDRAIN, S_SPIN};
    timed     = state_q inside {S_WASH, S_RINSE, S_SPIN};
    frozen    = timed && pause;
    tick      = (presc_q == PW'(TICK_DIV - 1));
    timeout   = tick && (tcnt_q == 8'(FILL_MAX - 1));
    phase_end = tick && !frozen && (timer_q == 8'd1);
    accept    = start && door_closed && (prog_bb || prog_cb || prog_sb);
  end

  // Next-state logic; an open door overrides any phase transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_FILL;
      S_FILL:   if (level_full) state_d = S_WASH;
                else if (timeout) state_d = S_FAULT;
      S_WASH:   if (phase_end) state_d = S_DRAIN;
      S_DRAIN:  if (level_empty) state_d = S_RFILL;
                else if (timeout) state_d = S_FAULT;
      S_RFILL:  if (level_full) state_d = S_RINSE;
                else if (timeout) state_d = S_FAULT;
      S_RINSE:  if (phase_end) state_d = S_RDRAIN;
      S_RDRAIN: if (level_empty) state_d = (rinse_q == 2'd1) ? S_SPIN : S_RFILL;
                else if (timeout) state_d = S_FAULT;
      S_SPIN:   if (phase_end) state_d = S_DONE;
      S_DONE:   if (!door_closed) state_d = S_IDLE;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_IDLE;
    endcase
    if (active && !door_closed) state_d = S_FAULT;
  end

  // Prescaler, phase timer, fill/drain tick counter, program and rinse latches.
  // The timer counts down in timed phases; fill/drain phases use a separate
  // up-counter so remaining can simply mirror the timer.
  always_comb begin
    prog_d  = prog_q;
    presc_d = presc_q;
    timer_d = timer_q;
    tcnt_d  = tcnt_q;
    rinse_d = rinse_q;
    ack_d   = 1'b0;

    if (state_q == S_IDLE && accept) begin
      ack_d   = 1'b1;
      prog_d  = prog_sb ? P_SB : (prog_cb ? P_CB : P_BB);
      rinse_d = (prog_sb || prog_cb) ? 2'd2 : 2'd1;
    end
    if (state_q == S_RDRAIN && level_empty) rinse_d = rinse_q - 2'd1;

    if (active && !frozen) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        if (timed) timer_d = timer_q - 8'd1;
        else       tcnt_d  = tcnt_q + 8'd1;
      end
    end

    if (state_d != state_q) begin
      presc_d = '0;
      tcnt_d  = '0;
      case (state_d)
        S_WASH:  timer_d = (prog_q == P_SB) ? 8'(WASH_SB) :
                           (prog_q == P_CB) ? 8'(WASH_CB) : 8'(WASH_BB);
        S_RINSE: timer_d = 8'(RINSE_T);
        S_SPIN:  timer_d = (prog_q == P_SB) ? 8'(SPIN_SB) : 8'(SPIN_T);
        default: timer_d = '0;
      endcase
    end
  end

  // Moore output decode; pause only gates the motors, FAULT drains until empty
  always_comb begin
    start_ack   = ack_q;
    phase       = state_q;
    busy        = !(state_q inside {S_IDLE, S_DONE});
    door_lock   = active || (state_q == S_FAULT && !level_empty);
    fill_valve  = state_q inside {S_FILL, S_RFILL};
    drain_valve = (state_q inside {S_DRAIN, S_RDRAIN, S_SPIN}) ||
                  (state_q == S_FAULT && !level_empty);
    motor_wash  = (state_q inside {S_WASH, S_RINSE}) && !pause;
    motor_spin  = (state_q == S_SPIN) && !pause;
    done        = (state_q == S_DONE);
    fault       = (state_q == S_FAULT);
    remaining   = timed ? timer_q : '0;
  end

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// Testbench for wash_cycle_sequencer: start-acceptance vector table,
// directed corner sequences, and randomized full cycles checked against
// a phase/duration reference model.
module tb_wash_cycle_sequencer;

  localparam int unsigned TD  = 4;
  localparam int unsigned WBB = 2;
  localparam int unsigned WCB = 3;
  localparam int unsigned WSB = 12;
  localparam int unsigned RT  = 1;
  localparam int unsigned ST  = 2;
  localparam int unsigned SSB = 3;
  localparam int unsigned FM  = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0, prog_bb = 1'b0, prog_cb = 1'b0, prog_sb = 1'b0;
  logic door_closed = 1'b1;
  logic level_full = 1'b0, level_empty = 1'b1;
  logic pause = 1'b0;
  logic start_ack, busy, door_lock, fill_valve, drain_valve;
  logic motor_wash, motor_spin, done, fault;
  logic [3:0] phase;
  logic [7:0] remaining;
  logic [20:0] outs;

  int n_checks = 0;
  int n_errors = 0;

  // Tub model controls
  bit env_on = 1'b0;
  bit frc_full = 1'b0, frc_empty = 1'b1;
  int fdly = 3, ddly = 3, fcnt = 0, dcnt = 0;

  typedef struct { int ph; int len; } seg_t;
  typedef struct { bit st; bit bb; bit cb; bit sb; bit door; bit exp_ack; int exp_phase; } vec_t;

  wash_cycle_sequencer #(
    .TICK_DIV(TD), .WASH_BB(WBB), .WASH_CB(WCB), .WASH_SB(WSB),
    .RINSE_T(RT), .SPIN_T(ST), .SPIN_SB(SSB), .FILL_MAX(FM)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .prog_bb(prog_bb), .prog_cb(prog_cb), .prog_sb(prog_sb),
    .door_closed(door_closed), .level_full(level_full), .level_empty(level_empty),
    .pause(pause), .start_ack(start_ack), .busy(busy), .door_lock(door_lock),
    .fill_valve(fill_valve), .drain_valve(drain_valve), .motor_wash(motor_wash),
    .motor_spin(motor_spin), .done(done), .fault(fault), .phase(phase),
    .remaining(remaining)
  );

  assign outs = {start_ack, busy, door_lock, fill_valve, drain_valve, motor_wash,
                 motor_spin, done, fault, phase, remaining};

  always #5 clk = ~clk;

  // Tub: level_full rises fdly cycles after filling starts, level_empty ddly
  // cycles after draining starts; otherwise forced values are applied.
  always @(posedge clk) begin
    #2;
    if (!env_on) begin
      level_full  = frc_full;
      level_empty = frc_empty;
      fcnt = 0;
      dcnt = 0;
    end else begin
      if (fill_valve) begin
        level_empty = 1'b0;
        fcnt++;
        if (fcnt >= fdly) level_full = 1'b1;
      end else fcnt = 0;
      if (drain_valve) begin
        level_full = 1'b0;
        dcnt++;
        if (dcnt >= ddly) level_empty = 1'b1;
      end else dcnt = 0;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    env_on = 1'b0; frc_full = 1'b0; frc_empty = 1'b1;
    start = 1'b0; prog_bb = 1'b0; prog_cb = 1'b0; prog_sb = 1'b0;
    pause = 1'b0; door_closed = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_outputs_zero", outs, 0);
    reset = 1'b1;
  endtask

  task automatic wait_phase(input int p, input string nm);
    for (int i = 0; i < 300 && phase != p; i++) @(negedge clk);
    check(nm, phase, p);
  endtask

  // Full cycle: capture (phase, length) segments and compare with a list
  // derived from the program's durations and the tub delays.
  task automatic run_cycle(input bit bb, input bit cb, input bit sb, input int f, input int d);
    seg_t exp_q[$];
    seg_t got_q[$];
    int w, s, nr, cur, len, n;
    w  = sb ? WSB : (cb ? WCB : WBB);
    s  = sb ? SSB : ST;
    nr = (cb || sb) ? 2 : 1;
    exp_q.push_back('{1, f});
    exp_q.push_back('{2, w * TD});
    exp_q.push_back('{3, d});
    for (int r = 0; r < nr; r++) begin
      exp_q.push_back('{4, f});
      exp_q.push_back('{5, RT * TD});
      exp_q.push_back('{6, d});
    end
    exp_q.push_back('{7, s * TD});

    do_reset();
    fdly = f; ddly = d; env_on = 1'b1;
    start = 1'b1; prog_bb = bb; prog_cb = cb; prog_sb = sb;
    @(negedge clk);
    check("run_start_ack", start_ack, 1);
    start = 1'b0; prog_bb = 1'b0; prog_cb = 1'b0; prog_sb = 1'b0;
    cur = phase; len = 1;
    for (int i = 0; i < 2000 && cur != 8; i++) begin
      @(negedge clk);
      if (phase == cur) len++;
      else begin
        got_q.push_back('{cur, len});
        cur = phase; len = 1;
      end
    end
    check("run_reach_done", cur, 8);
    check("run_num_phases", got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("run_seg%0d_phase", i), got_q[i].ph, exp_q[i].ph);
      check($sformatf("run_seg%0d_len", i), got_q[i].len, exp_q[i].len);
    end
    check("done_flag", done, 1);
    check("done_unlock", door_lock, 0);
    check("done_not_busy", busy, 0);
    start = 1'b1; prog_bb = 1'b1;
    @(negedge clk);
    check("done_start_ignored", start_ack, 0);
    check("done_stays", phase, 8);
    start = 1'b0; prog_bb = 1'b0;
    door_closed = 1'b0;
    @(negedge clk);
    check("done_door_to_idle", phase, 0);
    door_closed = 1'b1;
  endtask

  initial begin
    vec_t vt[7];
    int acks, cnt;
    bit b, c, s;

    vt[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1};
    vt[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    vt[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    vt[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0};
    vt[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1};
    vt[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1};
    vt[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1};

    @(negedge clk);
    @(negedge clk);

    // Start acceptance table, each vector from a fresh reset
    for (int i = 0; i < 7; i++) begin
      do_reset();
      start = vt[i].st; prog_bb = vt[i].bb; prog_cb = vt[i].cb; prog_sb = vt[i].sb;
      door_closed = vt[i].door;
      @(negedge clk);
      check($sformatf("vec%0d_ack", i), start_ack, vt[i].exp_ack);
      check($sformatf("vec%0d_phase", i), phase, vt[i].exp_phase);
      check($sformatf("vec%0d_fill", i), fill_valve, vt[i].exp_ack);
      start = 1'b0; prog_bb = 1'b0; prog_cb = 1'b0; prog_sb = 1'b0; door_closed = 1'b1;
      @(negedge clk);
      check($sformatf("vec%0d_ack_pulse", i), start_ack, 0);
    end

    // Reset mid-WASH, then a held start acks exactly once
    do_reset();
    fdly = 3; ddly = 3; env_on = 1'b1;
    start = 1'b1; prog_cb = 1'b1;
    @(negedge clk);
    start = 1'b0; prog_cb = 1'b0;
    wait_phase(2, "rst_reach_wash");
    check("rst_wash_rem3", remaining, 3);
    do_reset();
    start = 1'b1; prog_cb = 1'b1;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      acks += int'(start_ack);
    end
    check("rst_single_ack", acks, 1);
    start = 1'b0; prog_cb = 1'b0;

    // Directed full cycles: BB, CB (two rinses), BB+SB uses SB durations
    run_cycle(1'b1, 1'b0, 1'b0, 3, 3);
    run_cycle(1'b0, 1'b1, 1'b0, 3, 3);
    run_cycle(1'b1, 1'b0, 1'b1, 3, 3);

    // Pause for 10 cycles in WASH at remaining=2 stretches WASH by 10
    do_reset();
    fdly = 3; ddly = 3; env_on = 1'b1;
    start = 1'b1; prog_bb = 1'b1;
    @(negedge clk);
    start = 1'b0; prog_bb = 1'b0;
    wait_phase(2, "pause_reach_wash");
    check("pause_motor_before", motor_wash, 1);
    check("pause_rem_before", remaining, 2);
    cnt = 1;
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (phase == 2) cnt++;
      check("pause_motor_off", motor_wash, 0);
      check("pause_rem_hold", remaining, 2);
    end
    check("pause_lock_kept", door_lock, 1);
    pause = 1'b0;
    for (int i = 0; i < 100 && phase == 2; i++) begin
      @(negedge clk);
      if (phase == 2) cnt++;
    end
    check("pause_wash_len", cnt, WBB * TD + 10);
    check("pause_next_drain", phase, 3);

    // Door opened in SPIN -> FAULT, drains then unlocks, start ignored
    do_reset();
    fdly = 2; ddly = 2; env_on = 1'b1;
    start = 1'b1; prog_bb = 1'b1;
    @(negedge clk);
    start = 1'b0; prog_bb = 1'b0;
    wait_phase(7, "door_reach_spin");
    frc_full = 1'b0; frc_empty = 1'b0; env_on = 1'b0;
    @(negedge clk);
    door_closed = 1'b0;
    @(negedge clk);
    check("door_fault_phase", phase, 9);
    check("door_fault_flag", fault, 1);
    check("door_fault_drain", drain_valve, 1);
    check("door_fault_lock", door_lock, 1);
    check("door_fault_motor", motor_spin, 0);
    frc_empty = 1'b1;
    @(negedge clk);
    check("door_empty_drain", drain_valve, 0);
    check("door_empty_unlock", door_lock, 0);
    check("door_fault_held", fault, 1);
    door_closed = 1'b1; start = 1'b1; prog_bb = 1'b1;
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      acks += int'(start_ack);
    end
    check("fault_start_no_ack", acks, 0);
    check("fault_sticky", phase, 9);
    start = 1'b0; prog_bb = 1'b0;

    // Fill timeout after FILL_MAX*TICK_DIV cycles; start while busy ignored
    do_reset();
    start = 1'b1; prog_bb = 1'b1;
    @(negedge clk);
    check("to_start_ack", start_ack, 1);
    start = 1'b0; prog_bb = 1'b0;
    cnt = 1;
    acks = 0;
    for (int i = 0; i < 100 && phase == 1; i++) begin
      start = (i == 3 || i == 4);
      prog_cb = start;
      @(negedge clk);
      acks += int'(start_ack);
      if (phase == 1) cnt++;
    end
    start = 1'b0; prog_cb = 1'b0;
    check("to_busy_no_ack", acks, 0);
    check("to_fill_len", cnt, FM * TD);
    check("to_fault_phase", phase, 9);
    check("to_fault_flag", fault, 1);

    // Randomized programs and tub delays
    for (int r = 0; r < 8; r++) begin
      do begin
        b = 1'($urandom); c = 1'($urandom); s = 1'($urandom);
      end while (!(b || c || s));
      run_cycle(b, c, s, int'($urandom_range(1, 6)), int'($urandom_range(1, 6)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
